pattern_game_seq: RTL and testbench

//  Parametrised memory-game sequencer; successor to the 1-bit classic-mode FSM. Stores multi-bit symbols
//  (2**SYM_W buttons) in a MAX_LEN-deep pattern buffer and grows the pattern by one symbol per round.

---
 rtl/pattern_game_pkg.sv | 29 ++
 rtl/lfsr_sym_gen.sv | 33 +++
 rtl/pattern_game_seq.sv | 228 ++++++++++++++++++++++
 tb/tb_pattern_game_seq.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_game_pkg.sv
//==============================================================================
// Module   : pattern_game_pkg
// Desc     : Shared types and LFSR helper for the memory-game sequencer.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package pattern_game_pkg;

    localparam int                LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GEN     = 3'd1,
        SHOW    = 3'd2,
        WAIT_IN = 3'd3,
        FAIL    = 3'd4,
        WIN     = 3'd5
    } state_e;

    // Right-shifting Galois step: feedback bit is the bit shifted out.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        lfsr_next = (cur >> 1) ^ (cur[0] ? LFSR_TAPS : '0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr_sym_gen.sv
//==============================================================================
// Module   : lfsr_sym_gen
// Desc     : Free-running 16-bit Galois LFSR; exposes the low SYM_W bits.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module lfsr_sym_gen
    import pattern_game_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED  = 16'hACE1,
    parameter int                SYM_W = 2
)(
    input  logic             clk,
    input  logic             rst_n,
    output logic [SYM_W-1:0] sym
);

    logic [LFSR_W-1:0] r_lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign sym = r_lfsr[SYM_W-1:0];

endmodule

`default_nettype wire

// File: rtl/pattern_game_seq.sv
//==============================================================================
// Module   : pattern_game_seq
// Desc     : Memory-game sequencer: grows a random symbol pattern each round,
//            plays it back over valid/ready and checks the user's presses.
// Config   : define PATTERN_TIMEOUT_EN to fail a round after TMO_CYC idle cycles
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module pattern_game_seq
    import pattern_game_pkg::*;
#(
    parameter int                SYM_W   = 2,
    parameter int                MAX_LEN = 16,
    parameter logic [LFSR_W-1:0] SEED    = 16'hACE1,
    parameter int                TMO_CYC = 1000,
    localparam int               LEN_W   = $clog2(MAX_LEN + 1)
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             play_again,
    output logic             show_valid,
    output logic [SYM_W-1:0] show_sym,
    input  logic             show_ready,
    output logic             in_ready,
    input  logic             in_valid,
    input  logic [SYM_W-1:0] in_sym,
    output logic [LEN_W-1:0] level,
    output logic [LEN_W-1:0] score,
    output logic             busy,
    output logic             game_over,
    output logic             win,
    output logic             timed_out
);

    localparam int IDX_W = $clog2(MAX_LEN);

    if (SEED == '0 || MAX_LEN < 2 || TMO_CYC < 1) begin : g_param_check
        $error("pattern_game_seq: SEED must be nonzero, MAX_LEN >= 2, TMO_CYC >= 1");
    end

    state_e           r_state;
    state_e           w_next_state;
    logic [LEN_W-1:0] r_level;
    logic [LEN_W-1:0] r_score;
    logic [LEN_W-1:0] r_idx;
    logic [SYM_W-1:0] r_buf [MAX_LEN];
    logic             r_chk;
    logic             r_match;
    logic [SYM_W-1:0] w_new_sym;
    logic             w_last;
    logic             w_show_hs;
    logic             w_press;
    logic             w_restart;
    logic             w_full;
    logic             w_tmo;

    lfsr_sym_gen #(
        .SEED  (SEED),
        .SYM_W (SYM_W)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .sym   (w_new_sym)
    );

    assign w_last    = (r_idx == r_level - LEN_W'(1));
    assign w_show_hs = (r_state == SHOW) && show_ready;
    // A press is only taken while no comparison result is pending.
    assign w_press   = (r_state == WAIT_IN) && !r_chk && in_valid;
    assign w_restart = start || play_again;
    assign w_full    = (r_level == LEN_W'(MAX_LEN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = GEN;
            GEN:     w_next_state = SHOW;
            SHOW:    if (w_show_hs && w_last) w_next_state = WAIT_IN;
            WAIT_IN: begin
                if (r_chk) begin
                    if (!r_match)    w_next_state = FAIL;
                    else if (w_last) w_next_state = w_full ? WIN : GEN;
                end else if (w_tmo) begin
                    w_next_state = FAIL;
                end
            end
            FAIL,
            WIN:     if (w_restart) w_next_state = GEN;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        show_valid = 1'b0;
        show_sym   = '0;
        in_ready   = 1'b0;
        busy       = 1'b0;
        game_over  = 1'b0;
        win        = 1'b0;
        case (r_state)
            GEN:     busy = 1'b1;
            SHOW: begin
                busy       = 1'b1;
                show_valid = 1'b1;
                show_sym   = r_buf[r_idx[IDX_W-1:0]];
            end
            WAIT_IN: begin
                busy     = 1'b1;
                in_ready = !r_chk;
            end
            FAIL:    game_over = 1'b1;
            WIN: begin
                game_over = 1'b1;
                win       = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= '0;
            r_score <= '0;
            r_idx   <= '0;
            r_chk   <= 1'b0;
            r_match <= 1'b0;
        end else begin
            r_chk <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_level <= '0;
                        r_score <= '0;
                    end
                end
                GEN: begin
                    r_level <= r_level + LEN_W'(1);
                    r_idx   <= '0;
                end
                SHOW: begin
                    if (w_show_hs) begin
                        r_idx <= w_last ? '0 : r_idx + LEN_W'(1);
                    end
                end
                WAIT_IN: begin
                    if (r_chk) begin
                        if (r_match) begin
                            if (w_last) begin
                                r_score <= r_score + LEN_W'(1);
                            end else begin
                                r_idx <= r_idx + LEN_W'(1);
                            end
                        end
                    end else if (w_press) begin
                        r_chk   <= 1'b1;
                        r_match <= (in_sym == r_buf[r_idx[IDX_W-1:0]]);
                    end
                end
                FAIL,
                WIN: begin
                    if (w_restart) begin
                        r_level <= '0;
                        r_score <= '0;
                    end
                end
                default: r_idx <= '0;
            endcase
        end
    end

    // Pattern storage needs no reset; entries are written before they are read.
    always_ff @(posedge clk) begin
        if (r_state == GEN) begin
            r_buf[r_level[IDX_W-1:0]] <= w_new_sym;
        end
    end

    assign level = r_level;
    assign score = r_score;

`ifdef PATTERN_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_timed_out;

    // A press on the terminal count cycle wins over the timeout.
    assign w_tmo = (r_state == WAIT_IN) && !r_chk && !in_valid &&
                   (r_tmo_cnt == TMO_W'(TMO_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt   <= '0;
            r_timed_out <= 1'b0;
        end else begin
            if (r_state != WAIT_IN || w_press) begin
                r_tmo_cnt <= '0;
            end else if (!w_tmo) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end

            if (w_tmo) begin
                r_timed_out <= 1'b1;
            end else if ((r_state == FAIL || r_state == WIN) && w_restart) begin
                r_timed_out <= 1'b0;
            end
        end
    end

    assign timed_out = r_timed_out;
`else
    assign w_tmo     = 1'b0;
    assign timed_out = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pattern_game_seq.sv
//==============================================================================
// Module   : tb_pattern_game_seq
// Desc     : Randomised scoreboard bench for pattern_game_seq (MAX_LEN=4).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pattern_game_seq;

    localparam int          SYM_W   = 2;
    localparam int          MAX_LEN = 4;
    localparam int          TMO_CYC = 20;
    localparam logic [15:0] SEED    = 16'hACE1;
    localparam int          LEN_W   = $clog2(MAX_LEN + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             play_again = 1'b0;
    logic             show_valid;
    logic [SYM_W-1:0] show_sym;
    logic             show_ready = 1'b0;
    logic             in_ready;
    logic             in_valid = 1'b0;
    logic [SYM_W-1:0] in_sym = '0;
    logic [LEN_W-1:0] level;
    logic [LEN_W-1:0] score;
    logic             busy;
    logic             game_over;
    logic             win;
    logic             timed_out;

    pattern_game_seq #(
        .SYM_W   (SYM_W),
        .MAX_LEN (MAX_LEN),
        .SEED    (SEED),
        .TMO_CYC (TMO_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .play_again (play_again),
        .show_valid (show_valid),
        .show_sym   (show_sym),
        .show_ready (show_ready),
        .in_ready   (in_ready),
        .in_valid   (in_valid),
        .in_sym     (in_sym),
        .level      (level),
        .score      (score),
        .busy       (busy),
        .game_over  (game_over),
        .win        (win),
        .timed_out  (timed_out)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int mon_errors = 0;
    int mon_checks = 0;

    logic [SYM_W-1:0] pattern [$];
    logic [SYM_W-1:0] exp_q   [$];
    logic [SYM_W-1:0] first_shown;
    bit               stall_hold = 1'b0;

    // Reference random source: x^16 Galois register, one step per clock out of reset.
    function automatic logic [15:0] galois_step(input logic [15:0] v);
        logic [15:0] poly;
        poly = 16'hB400;
        return v[0] ? ((v >> 1) ^ poly) : (v >> 1);
    endfunction

    logic [15:0] m_lfsr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= SEED;
        else        m_lfsr <= galois_step(m_lfsr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Display back-pressure: random unless a stall is being forced.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            show_ready = stall_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: every playback handshake pops the next expected symbol.
    initial begin
        logic [SYM_W-1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && show_valid === 1'b1 && show_ready === 1'b1) begin
                mon_checks++;
                if (exp_q.size() == 0) begin
                    mon_errors++;
                    $display("FAIL show_unexpected: got sym %0d, expected no playback", show_sym);
                end else begin
                    e = exp_q.pop_front();
                    if (show_sym !== e) begin
                        mon_errors++;
                        $display("FAIL show_sym: got %0d, expected %0d", show_sym, e);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_show_valid"}, show_valid, 0);
        check({tag, "_show_sym"},   show_sym,   0);
        check({tag, "_in_ready"},   in_ready,   0);
        check({tag, "_level"},      level,      0);
        check({tag, "_score"},      score,      0);
        check({tag, "_busy"},       busy,       0);
        check({tag, "_game_over"},  game_over,  0);
        check({tag, "_win"},        win,        0);
        check({tag, "_timed_out"},  timed_out,  0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pattern.delete();
        exp_q.delete();
        #1;
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic record_gen();
        pattern.push_back(m_lfsr[SYM_W-1:0]);
        foreach (pattern[i]) exp_q.push_back(pattern[i]);
    endtask

    task automatic kick(input bit use_start, input bit use_again, input bit rec_first, input bit chk_first);
        @(posedge clk);
        #1;
        start      = use_start;
        play_again = use_again;
        @(posedge clk);
        #1;
        start      = 1'b0;
        play_again = 1'b0;
        @(negedge clk);
        check("gen_busy", busy, 1);
        check("gen_show_valid", show_valid, 0);
        check("gen_score_cleared", score, 0);
        pattern.delete();
        record_gen();
        @(negedge clk);
        check("show_after_2cyc", show_valid, 1);
        check("show_level", level, 1);
        if (rec_first) first_shown = show_sym;
        if (chk_first) check("reseed_first_sym", show_sym, first_shown);
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL in_ready_wait: got no in_ready in 300 cycles, expected in_ready=1");
    endtask

    task automatic play_round(input int wrong_at, input int gap);
        bit               ok;
        int               len;
        int               g;
        logic [SYM_W-1:0] s;
        len = pattern.size();
        wait_ready(ok);
        if (!ok) return;
        check("wait_level", level, len);
        check("playback_drained", exp_q.size(), 0);
        check("wait_show_valid", show_valid, 0);
        for (int i = 0; i < len; i++) begin
            s = pattern[i];
            if (i == wrong_at) s = s ^ SYM_W'(1);
            g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            repeat (g) @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_sym   = s;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_sym   = SYM_W'($urandom);
            @(posedge clk);
            if (i == wrong_at) begin
                @(negedge clk);
                check("fail_game_over", game_over, 1);
                check("fail_win", win, 0);
                check("fail_busy", busy, 0);
                check("fail_score", score, len - 1);
                return;
            end
        end
        @(negedge clk);
        check("round_score", score, len);
        if (len == MAX_LEN) begin
            check("win_win", win, 1);
            check("win_game_over", game_over, 1);
            check("win_busy", busy, 0);
            check("win_level", level, MAX_LEN);
        end else begin
            check("next_gen_busy", busy, 1);
            check("next_gen_show_valid", show_valid, 0);
            record_gen();
        end
    endtask

    task automatic stall_test();
        int               sz0;
        bit               seen;
        logic [SYM_W-1:0] ref_sym;
        sz0  = exp_q.size();
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() < sz0) seen = 1'b1;
        end
        check("stall_first_consumed", seen, 1);
        stall_hold = 1'b1;
        @(posedge clk);
        #2;
        @(negedge clk);
        ref_sym = show_sym;
        sz0     = exp_q.size();
        check("stall_valid", show_valid, 1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #2;
            in_valid = 1'b1;
            in_sym   = ref_sym ^ SYM_W'(1);
            @(negedge clk);
            check("stall_sym_stable", show_sym, ref_sym);
            check("stall_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        check("stall_idx_held", exp_q.size(), sz0);
        stall_hold = 1'b0;
    endtask

    initial begin
        bit ok;
        int bad;

        // Game 1: straight run to WIN, with a forced stall during level 3 playback.
        do_reset();
        kick(1'b1, 1'b0, 1'b1, 1'b0);
        play_round(-1, -1);
        play_round(-1, -1);
        stall_test();
        play_round(-1, -1);
        play_round(-1, -1);

        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_sym   = pattern[0] ^ SYM_W'(1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("win_ignores_press", win, 1);
        check("win_score_hold", score, MAX_LEN);

        // Game 2: restart with both buttons, start while busy, wrong press at idx 1 of level 3.
        kick(1'b1, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        play_round(-1, -1);
        play_round(-1, -1);
        play_round(1, -1);

        @(posedge clk);
        #1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("fail_hold_over", game_over, 1);
        check("fail_hold_score", score, 2);

        // Game 3: reset while waiting for input, then replay from the seed.
        kick(1'b0, 1'b1, 1'b0, 1'b0);
        play_round(-1, -1);
        wait_ready(ok);
        @(posedge clk);
        #1;
        do_reset();
        @(negedge clk);
        check("post_reset_busy", busy, 0);
        kick(1'b1, 1'b0, 1'b0, 1'b1);
        play_round(-1, 17);
        play_round(-1, 17);
        wait_ready(ok);
`ifdef PATTERN_TIMEOUT_EN
        bad = 0;
        for (int k = 1; k < TMO_CYC; k++) begin
            @(negedge clk);
            if (game_over !== 1'b0) bad++;
        end
        check("no_early_timeout", bad, 0);
        @(negedge clk);
        check("tmo_game_over", game_over, 1);
        check("tmo_timed_out", timed_out, 1);
        check("tmo_busy", busy, 0);
        check("tmo_score", score, 2);
        kick(1'b0, 1'b1, 1'b0, 1'b0);
        check("tmo_cleared", timed_out, 0);
        play_round(-1, -1);
`else
        bad = 0;
        for (int k = 0; k < 2 * TMO_CYC; k++) begin
            @(negedge clk);
            if (game_over !== 1'b0 || timed_out !== 1'b0) bad++;
        end
        check("no_timeout_logic", bad, 0);
        check("still_waiting", in_ready, 1);
        play_round(-1, -1);
`endif
        repeat (4) @(posedge clk);
        errors += mon_errors;
        checks += mon_checks;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
